// File: rtl/load_unit_pkg.sv
// Shared load/store-path definitions: default widths and load unit state encodings.
package load_unit_pkg;

    localparam int unsigned LU_ADDR_W = 16;
    localparam int unsigned LU_DATA_W = 16;
    localparam int unsigned LU_TAG_W  = 4;
    localparam int unsigned LU_DEPTH  = 4;

    typedef enum logic [1:0] {
        LU_IDLE  = 2'd0,
        LU_WAIT  = 2'd1,
        LU_BCAST = 2'd2,
        LU_DRAIN = 2'd3
    } lu_state_e;

endpackage

// File: rtl/load_unit_queue.sv
// load_queue: in-order synchronous FIFO holding issued loads.
//   clk, reset      clock, async active-high reset
//   clear_i         sync clear of all entries (flush)
//   push_i/data_i   write request and entry; ignored when full
//   pop_i/data_o    read request and head entry; ignored when empty
//   full_o/empty_o  registered status flags
module load_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    // Next occupancy; clear dominates any same-cycle push/pop
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Pointers, count and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (clear_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CNT_W'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    // Entry storage needs no reset: validity is tracked by the count
    always_ff @(posedge clk) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/load_unit.sv
// load_unit: read-side memory port of the load/store path.
//   Queues issued loads in order, runs one memory read at a time, forwards a
//   snooped store that hits the outstanding address, and presents the result
//   on the CDB until granted.
//   clk, reset                         clock, async active-high reset
//   flush                              squash queued and in-flight loads
//   load_en/load_addr/load_tag         issue port, load_ready = queue not full
//   mem_read_req/addr/valid/data       memory read handshake
//   mem_write_en/addr/data             snooped store write port
//   cdb_valid/tag/data, cdb_grant      result broadcast handshake
module load_unit
    import load_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = LU_ADDR_W,
    parameter int unsigned DATA_W = LU_DATA_W,
    parameter int unsigned TAG_W  = LU_TAG_W,
    parameter int unsigned DEPTH  = LU_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [TAG_W-1:0]  load_tag,
    output logic              load_ready,
    output logic              mem_read_req,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic              mem_read_valid,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_write_en,
    input  logic [ADDR_W-1:0] mem_write_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_grant
);

    localparam int unsigned ENTRY_W = ADDR_W + TAG_W;

    lu_state_e          state_q, state_d;
    logic [ADDR_W-1:0]  cur_addr_q, cur_addr_d;
    logic [TAG_W-1:0]   cur_tag_q, cur_tag_d;
    logic               fwd_hit_q, fwd_hit_d;
    logic [DATA_W-1:0]  fwd_data_q, fwd_data_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;

    logic               q_push, q_pop, q_full, q_empty;
    logic [ENTRY_W-1:0] q_head;
    logic [ADDR_W-1:0]  head_addr;
    logic [TAG_W-1:0]   head_tag;
    logic               snoop_hit;

    // Flush blocks any same-cycle issue or dequeue
    assign q_push    = load_en && !q_full && !flush;
    assign q_pop     = (state_q == LU_IDLE) && !q_empty && !flush;
    assign head_addr = q_head[ENTRY_W-1:TAG_W];
    assign head_tag  = q_head[TAG_W-1:0];
    assign snoop_hit = mem_write_en && (mem_write_addr == cur_addr_q);

    load_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .clear_i (flush),
        .push_i  (q_push),
        .data_i  ({load_addr, load_tag}),
        .pop_i   (q_pop),
        .data_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LU_IDLE;
            cur_addr_q  <= '0;
            cur_tag_q   <= '0;
            fwd_hit_q   <= 1'b0;
            fwd_data_q  <= '0;
            req_q       <= 1'b0;
            rd_addr_q   <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_tag_q   <= cur_tag_d;
            fwd_hit_q   <= fwd_hit_d;
            fwd_data_q  <= fwd_data_d;
            req_q       <= req_d;
            rd_addr_q   <= rd_addr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_tag_d   = cur_tag_q;
        fwd_hit_d   = fwd_hit_q;
        fwd_data_d  = fwd_data_q;
        req_d       = req_q;
        rd_addr_d   = rd_addr_q;
        cdb_valid_d = cdb_valid_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;

        unique case (state_q)
            LU_IDLE: begin
                if (flush) begin
                    cdb_valid_d = 1'b0;
                end else if (!q_empty) begin
                    cur_addr_d = head_addr;
                    cur_tag_d  = head_tag;
                    fwd_hit_d  = 1'b0;
                    req_d      = 1'b1;
                    rd_addr_d  = head_addr;
                    state_d    = LU_WAIT;
                end
            end
            LU_WAIT: begin
                if (flush) begin
                    cdb_valid_d = 1'b0;
                    // A response arriving with the flush is swallowed right here
                    if (mem_read_valid) begin
                        req_d   = 1'b0;
                        state_d = LU_IDLE;
                    end else begin
                        state_d = LU_DRAIN;
                    end
                end else begin
                    if (snoop_hit) begin
                        fwd_hit_d  = 1'b1;
                        fwd_data_d = mem_write_data;
                    end
                    if (mem_read_valid) begin
                        req_d       = 1'b0;
                        cdb_valid_d = 1'b1;
                        cdb_tag_d   = cur_tag_q;
                        cdb_data_d  = snoop_hit ? mem_write_data :
                                      fwd_hit_q ? fwd_data_q : mem_read_data;
                        state_d     = LU_BCAST;
                    end
                end
            end
            LU_BCAST: begin
                if (flush || cdb_grant) begin
                    cdb_valid_d = 1'b0;
                    state_d     = LU_IDLE;
                end
            end
            LU_DRAIN: begin
                cdb_valid_d = 1'b0;
                if (mem_read_valid) begin
                    req_d   = 1'b0;
                    state_d = LU_IDLE;
                end
            end
            default: begin
                state_d = LU_IDLE;
            end
        endcase
    end

    assign load_ready    = !q_full;
    assign mem_read_req  = req_q;
    assign mem_read_addr = rd_addr_q;
    assign cdb_valid     = cdb_valid_q;
    assign cdb_tag       = cdb_tag_q;
    assign cdb_data      = cdb_data_q;

endmodule

// File: tb/tb_load_unit.sv
// Directed testbench for load_unit with an expected-result scoreboard.
module tb_load_unit;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned TW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          load_en = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [TW-1:0] load_tag = '0;
    logic          load_ready;
    logic          mem_read_req;
    logic [AW-1:0] mem_read_addr;
    logic          mem_read_valid = 1'b0;
    logic [DW-1:0] mem_read_data = '0;
    logic          mem_write_en = 1'b0;
    logic [AW-1:0] mem_write_addr = '0;
    logic [DW-1:0] mem_write_data = '0;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          cdb_grant = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [TW+DW-1:0] sb_q[$];

    load_unit dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .load_en        (load_en),
        .load_addr      (load_addr),
        .load_tag       (load_tag),
        .load_ready     (load_ready),
        .mem_read_req   (mem_read_req),
        .mem_read_addr  (mem_read_addr),
        .mem_read_valid (mem_read_valid),
        .mem_read_data  (mem_read_data),
        .mem_write_en   (mem_write_en),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_grant      (cdb_grant)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [TW-1:0] t);
        load_en   = 1'b1;
        load_addr = a;
        load_tag  = t;
        step();
        load_en   = 1'b0;
    endtask

    // Wait (bounded) for a read request and check its address
    task automatic wait_req(input string name, input logic [AW-1:0] a);
        int n = 0;
        while (!mem_read_req && n < 20) begin
            step();
            n++;
        end
        chk({name, "_req"}, 32'(mem_read_req), 32'd1);
        chk({name, "_addr"}, 32'(mem_read_addr), 32'(a));
    endtask

    // Return read data for one cycle and record the expected broadcast
    task automatic respond(input logic [DW-1:0] d, input logic [TW-1:0] t, input logic [DW-1:0] exp_d);
        sb_q.push_back({t, exp_d});
        mem_read_valid = 1'b1;
        mem_read_data  = d;
        step();
        mem_read_valid = 1'b0;
    endtask

    // Wait (bounded) for a broadcast, compare against the scoreboard, then grant it
    task automatic collect(input string name);
        int n = 0;
        logic [TW+DW-1:0] e;
        while (!cdb_valid && n < 20) begin
            step();
            n++;
        end
        chk({name, "_cdb_valid"}, 32'(cdb_valid), 32'd1);
        if (sb_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_tag"}, 32'(cdb_tag), 32'(e[TW+DW-1:DW]));
            chk({name, "_data"}, 32'(cdb_data), 32'(e[DW-1:0]));
        end
        cdb_grant = 1'b1;
        step();
        cdb_grant = 1'b0;
        chk({name, "_valid_drop"}, 32'(cdb_valid), 32'd0);
    endtask

    initial begin
        // Reset values
        step();
        step();
        reset = 1'b0;
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_req", 32'(mem_read_req), 32'd0);
        chk("rst_addr", 32'(mem_read_addr), 32'd0);
        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
        chk("rst_cdb_data", 32'(cdb_data), 32'd0);

        // 1: single load, exact latency
        issue(16'h0040, 4'd3);
        chk("t1_req_e0", 32'(mem_read_req), 32'd0);
        step();
        chk("t1_req_e1", 32'(mem_read_req), 32'd1);
        chk("t1_addr", 32'(mem_read_addr), 32'h0040);
        respond(16'hBEEF, 4'd3, 16'hBEEF);
        chk("t1_valid_e2", 32'(cdb_valid), 32'd1);
        chk("t1_req_drop", 32'(mem_read_req), 32'd0);
        collect("t1");

        // 2: one load in flight, then 5 pushes with memory stalled
        issue(16'h1000, 4'd0);
        step();
        chk("t2_inflight", 32'(mem_read_req), 32'd1);
        for (int i = 1; i <= 4; i++) issue(16'h1000 + AW'(i), TW'(i));
        chk("t2_ready_full", 32'(load_ready), 32'd0);
        issue(16'h1005, 4'd5);
        chk("t2_ready_still", 32'(load_ready), 32'd0);
        for (int i = 0; i <= 4; i++) begin
            wait_req("t2", 16'h1000 + AW'(i));
            respond(16'hA000 + DW'(i), TW'(i), 16'hA000 + DW'(i));
            collect("t2");
        end
        step();
        step();
        chk("t2_no_extra", 32'(mem_read_req), 32'd0);
        chk("t2_ready_back", 32'(load_ready), 32'd1);

        // 3: snooped store during WAIT forwards; latest write wins; other addr does not
        issue(16'h0100, 4'd5);
        wait_req("t3a", 16'h0100);
        mem_write_en = 1'b1; mem_write_addr = 16'h0100; mem_write_data = 16'h1111;
        step();
        mem_write_data = 16'h1234;
        step();
        mem_write_en = 1'b0;
        respond(16'h0000, 4'd5, 16'h1234);
        collect("t3a");
        issue(16'h0100, 4'd6);
        wait_req("t3b", 16'h0100);
        mem_write_en = 1'b1; mem_write_addr = 16'h0102; mem_write_data = 16'h9999;
        step();
        mem_write_en = 1'b0;
        respond(16'h4321, 4'd6, 16'h4321);
        collect("t3b");

        // 4: store hits in the same cycle as the read response
        issue(16'h0300, 4'd7);
        wait_req("t4", 16'h0300);
        mem_write_en = 1'b1; mem_write_addr = 16'h0300; mem_write_data = 16'h5555;
        respond(16'hAAAA, 4'd7, 16'h5555);
        mem_write_en = 1'b0;
        collect("t4");

        // 5: flush during WAIT with two queued and a same-cycle issue
        issue(16'h0500, 4'd8);
        step();
        issue(16'h0504, 4'd9);
        issue(16'h0508, 4'd10);
        flush = 1'b1;
        load_en = 1'b1; load_addr = 16'h050C; load_tag = 4'd12;
        step();
        flush = 1'b0;
        load_en = 1'b0;
        chk("t5_ready", 32'(load_ready), 32'd1);
        chk("t5_cdb", 32'(cdb_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("t5_drain_req", 32'(mem_read_req), 32'd1);
            step();
        end
        mem_read_valid = 1'b1; mem_read_data = 16'h7777;
        step();
        mem_read_valid = 1'b0;
        chk("t5_req_done", 32'(mem_read_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_idle_req", 32'(mem_read_req), 32'd0);
            chk("t5_idle_cdb", 32'(cdb_valid), 32'd0);
        end
        issue(16'h0600, 4'd11);
        wait_req("t5", 16'h0600);
        respond(16'h6666, 4'd11, 16'h6666);
        collect("t5");

        // 6: grant withheld keeps outputs stable; async reset in BCAST
        issue(16'h0700, 4'd13);
        wait_req("t6", 16'h0700);
        respond(16'hC0DE, 4'd13, 16'hC0DE);
        for (int i = 0; i < 5; i++) begin
            chk("t6_hold_valid", 32'(cdb_valid), 32'd1);
            chk("t6_hold_tag", 32'(cdb_tag), 32'd13);
            chk("t6_hold_data", 32'(cdb_data), 32'hC0DE);
            step();
        end
        void'(sb_q.pop_front());
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(cdb_valid), 32'd0);
        chk("t6_rst_tag", 32'(cdb_tag), 32'd0);
        chk("t6_rst_data", 32'(cdb_data), 32'd0);
        chk("t6_rst_req", 32'(mem_read_req), 32'd0);
        chk("t6_rst_ready", 32'(load_ready), 32'd1);
        step();
        reset = 1'b0;
        mem_read_valid = 1'b1; mem_read_data = 16'hDEAD;
        step();
        mem_read_valid = 1'b0;
        step();
        chk("t6_stale_valid", 32'(cdb_valid), 32'd0);
        chk("t6_stale_req", 32'(mem_read_req), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
